mac_table_lookup: RTL and testbench

// - Read side of the hash controller: resolves a MAC key to an egress port via the MAC hash table.
// - Folds the key to a bucket index and issues reads to an external synchronous table RAM.
// - Linear-probes until it finds the key, finds an empty slot, or reaches MAX_PROBES.
// - Returns hit/miss plus port on a valid/ready response channel.

---
 rtl/mac_table_lookup.sv | 194 +++++++++++++++++++
 tb/tb_mac_table_lookup.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_table_lookup.sv
// ---------------------------------------------------------------------------
// mac_table_lookup
//
// Read side of the MAC hash controller. It resolves a MAC key to an egress
// port by hashing the key to a bucket index and then reading an external
// synchronous table RAM. On a collision it moves to the next bucket, up to
// MAX_PROBES buckets in total. The search stops at the first matching entry,
// at the first empty slot, or when all MAX_PROBES buckets have been read.
//
// Ports
//   clk_i          clock
//   rst_n_i        synchronous active-low reset
//   req_valid_i    lookup request valid
//   req_ready_o    block can accept a request (IDLE only)
//   req_key_i      key to look up
//   rd_en_o        table read strobe, one cycle per probe
//   rd_addr_o      table read address, 0 when rd_en_o is low
//   rd_data_i      table entry {valid, key, port}, returned 1 cycle after rd_en_o
//   resp_valid_o   response valid
//   resp_ready_i   response consumed
//   resp_hit_o     1 = key found
//   resp_port_o    egress port on a hit, 0 on a miss
//   resp_probes_o  number of table reads issued for this lookup
// ---------------------------------------------------------------------------
module mac_table_lookup #(
    parameter int KEY_W      = 48,
    parameter int IDX_W      = 12,
    parameter int PORT_W     = 4,
    parameter int MAX_PROBES = 4,
    localparam int ENTRY_W   = 1 + KEY_W + PORT_W,
    localparam int PROBE_W   = $clog2(MAX_PROBES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [KEY_W-1:0]   req_key_i,
    output logic               rd_en_o,
    output logic [IDX_W-1:0]   rd_addr_o,
    input  logic [ENTRY_W-1:0] rd_data_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic               resp_hit_o,
    output logic [PORT_W-1:0]  resp_port_o,
    output logic [PROBE_W-1:0] resp_probes_o
);

    // Number of IDX_W-wide chunks folded into the hash; the top chunk is
    // zero-padded when KEY_W is not a multiple of IDX_W.
    localparam int NCHUNK = (KEY_W + IDX_W - 1) / IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_CMP,
        ST_RESP
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [KEY_W-1:0]     key_q;
    logic [PROBE_W-1:0]   probe_q;
    logic                 req_ready_q;
    logic                 resp_hit_q;
    logic [PORT_W-1:0]    resp_port_q;
    logic [PROBE_W-1:0]   resp_probes_q;

    logic [NCHUNK*IDX_W-1:0] key_pad;
    logic [IDX_W-1:0]        hash_idx;

    logic                 entry_valid;
    logic [KEY_W-1:0]     entry_key;
    logic [PORT_W-1:0]    entry_port;
    logic                 entry_hit;
    logic [PROBE_W-1:0]   probe_next;
    logic                 last_probe;
    logic                 accept;

    // -----------------------------------------------------------------------
    // Hash: XOR-fold of the latched key into IDX_W bits.
    // -----------------------------------------------------------------------
    always_comb begin
        key_pad              = '0;
        key_pad[KEY_W-1:0]   = key_q;
        hash_idx             = '0;
        for (int j = 0; j < NCHUNK; j++) begin
            hash_idx = hash_idx ^ key_pad[j*IDX_W +: IDX_W];
        end
    end

    // -----------------------------------------------------------------------
    // Entry decode and probe bookkeeping (only meaningful in ST_CMP).
    // -----------------------------------------------------------------------
    assign entry_valid = rd_data_i[ENTRY_W-1];
    assign entry_key   = rd_data_i[PORT_W +: KEY_W];
    assign entry_port  = rd_data_i[PORT_W-1:0];
    assign entry_hit   = entry_valid && (entry_key == key_q);
    assign probe_next  = probe_q + PROBE_W'(1);
    assign last_probe  = (probe_next == PROBE_W'(MAX_PROBES));

    // Ready is registered so that it stays low in the cycle right after a
    // reset edge and only rises once the block is out of reset.
    assign accept      = req_valid_i && req_ready_q;

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD:   state_d = ST_CMP;
            ST_CMP:  begin
                if (entry_hit || !entry_valid || last_probe) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RESP: if (resp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers: latched key, probe counter, response fields.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            key_q         <= '0;
            probe_q       <= '0;
            req_ready_q   <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_port_q   <= '0;
            resp_probes_q <= '0;
        end else begin
            req_ready_q <= (state_d == ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        key_q   <= req_key_i;
                        probe_q <= '0;
                    end
                end
                ST_CMP: begin
                    probe_q <= probe_next;
                    if (state_d == ST_RESP) begin
                        resp_hit_q    <= entry_hit;
                        resp_port_q   <= entry_hit ? entry_port : '0;
                        resp_probes_q <= probe_next;
                    end
                end
                ST_RESP: begin
                    // Fields return to 0 once the response is consumed.
                    if (resp_ready_i) begin
                        resp_hit_q    <= 1'b0;
                        resp_port_q   <= '0;
                        resp_probes_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_ready_o   = req_ready_q;
    assign rd_en_o       = (state_q == ST_RD);
    // Address addition wraps naturally at the table end (mod 2**IDX_W).
    assign rd_addr_o     = (state_q == ST_RD) ? (hash_idx + IDX_W'(probe_q)) : '0;
    assign resp_valid_o  = (state_q == ST_RESP);
    assign resp_hit_o    = resp_hit_q;
    assign resp_port_o   = resp_port_q;
    assign resp_probes_o = resp_probes_q;

endmodule

// File: tb/tb_mac_table_lookup.sv
// ---------------------------------------------------------------------------
// tb_mac_table_lookup
//
// Self-checking bench for mac_table_lookup with a 1-cycle synchronous table
// RAM model and a behavioural lookup reference (hash by arithmetic folding,
// linear probe over the table array).
// ---------------------------------------------------------------------------
module tb_mac_table_lookup;

    localparam int KEY_W      = 48;
    localparam int IDX_W      = 12;
    localparam int PORT_W     = 4;
    localparam int MAX_PROBES = 4;
    localparam int ENTRY_W    = 1 + KEY_W + PORT_W;
    localparam int PROBE_W    = $clog2(MAX_PROBES + 1);
    localparam int DEPTH      = 1 << IDX_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [KEY_W-1:0]   req_key;
    logic               rd_en;
    logic [IDX_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0] rd_data;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_hit;
    logic [PORT_W-1:0]  resp_port;
    logic [PROBE_W-1:0] resp_probes;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]   addr_q [$];
    int                 checks = 0;
    int                 passes = 0;
    bit                 mon_en = 1'b0;

    always #5 clk = ~clk;

    mac_table_lookup #(
        .KEY_W      (KEY_W),
        .IDX_W      (IDX_W),
        .PORT_W     (PORT_W),
        .MAX_PROBES (MAX_PROBES)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_key_i     (req_key),
        .rd_en_o       (rd_en),
        .rd_addr_o     (rd_addr),
        .rd_data_i     (rd_data),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_hit_o    (resp_hit),
        .resp_port_o   (resp_port),
        .resp_probes_o (resp_probes)
    );

    // Synchronous table RAM; garbage is returned when not read so that any
    // use of rd_data outside the compare cycle is likely to show up.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= ENTRY_W'({$urandom, $urandom});
    end

    // Read-address monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                addr_q.push_back(rd_addr);
            end else begin
                checks++;
                if (rd_addr !== '0) $display("FAIL rd_addr_idle: got %0h expected 0", rd_addr);
                else passes++;
            end
        end
    end

    // ---------------------------- reference model --------------------------
    function automatic logic [IDX_W-1:0] ref_hash(input logic [KEY_W-1:0] key);
        longint unsigned k = 64'(key);
        int h = 0;
        for (int j = 0; j < 4; j++) h = h ^ int'((k >> (12 * j)) % 4096);
        return IDX_W'(h);
    endfunction

    function automatic void ref_lookup(input logic [KEY_W-1:0] key, output logic hit,
                                       output logic [PORT_W-1:0] port, output int probes);
        int h = int'(ref_hash(key));
        logic [ENTRY_W-1:0] e;
        hit = 1'b0; port = '0; probes = 0;
        for (int i = 0; i < MAX_PROBES; i++) begin
            e = mem[(h + i) % DEPTH];
            probes = i + 1;
            if (!e[ENTRY_W-1]) break;
            if (e[PORT_W +: KEY_W] == key) begin
                hit = 1'b1; port = e[PORT_W-1:0];
                break;
            end
        end
    endfunction

    function automatic logic [ENTRY_W-1:0] ent(input logic v, input logic [KEY_W-1:0] k,
                                               input logic [PORT_W-1:0] p);
        return {v, k, p};
    endfunction

    function automatic logic [KEY_W-1:0] key_with_hash(input logic [IDX_W-1:0] h);
        logic [KEY_W-1:0] k = KEY_W'({$urandom, $urandom});
        k[IDX_W-1:0] = k[IDX_W-1:0] ^ ref_hash(k) ^ h;
        return k;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // Issue one lookup, wait for its response, hold it for rdy_delay cycles,
    // then consume it. lat counts cycles from acceptance to resp_valid (-1 on
    // timeout); stable reports whether fields held during backpressure; clean
    // reports whether all resp fields were 0 after the handshake.
    task automatic run_lookup(input logic [KEY_W-1:0] key, input int rdy_delay,
                              output int lat, output logic hit, output logic [PORT_W-1:0] port,
                              output logic [PROBE_W-1:0] probes, output int nreads,
                              output bit stable, output bit clean);
        int n = 0;
        lat = -1; hit = 1'bx; port = 'x; probes = 'x; nreads = -1; stable = 1'b0; clean = 1'b0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) return;
        addr_q.delete();
        req_key = key; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_key = KEY_W'({$urandom, $urandom});
        n = 1;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        if (!resp_valid) return;
        lat = n; hit = resp_hit; port = resp_port; probes = resp_probes;
        stable = 1'b1;
        for (int d = 0; d < rdy_delay; d++) begin
            @(negedge clk);
            if (!resp_valid || resp_hit !== hit || resp_port !== port || resp_probes !== probes)
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        clean = !resp_valid && resp_hit === 1'b0 && resp_port === '0 && resp_probes === '0;
        repeat (2) @(negedge clk);
        nreads = addr_q.size();
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_key = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_en, rd_addr, resp_valid, resp_hit, resp_port, resp_probes} !== '0)
            $display("FAIL reset_outputs: got %0h expected 0",
                     {rd_en, rd_addr, resp_valid, resp_hit, resp_port, resp_probes});
        else passes++;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready: got %0b expected 0", req_ready);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b expected 1", req_ready);
        else passes++;
        mon_en = 1'b1;
    endtask

    task automatic test_home_hit();
        logic [KEY_W-1:0] key = 48'h0011_2233_4455;
        int lat, nreads; logic hit; logic [PORT_W-1:0] port; logic [PROBE_W-1:0] probes;
        bit stable, clean;
        clear_mem();
        mem[12'h642] = ent(1'b1, key, 4'h5);
        run_lookup(key, 0, lat, hit, port, probes, nreads, stable, clean);
        checks++; if (lat !== 3) $display("FAIL home_latency: got %0d expected 3", lat); else passes++;
        checks++; if (nreads !== 1 || addr_q[0] !== 12'h642)
            $display("FAIL home_addr: got %0d reads first %0h expected 1 read of 642", nreads, addr_q[0]);
        else passes++;
        checks++; if ({hit, port, probes} !== {1'b1, 4'h5, 3'd1})
            $display("FAIL home_resp: got hit=%0b port=%0h probes=%0d expected 1/5/1", hit, port, probes);
        else passes++;
        checks++; if (clean !== 1'b1) $display("FAIL home_clear: got %0b expected 1", clean); else passes++;
    endtask

    task automatic test_probe_chain();
        logic [KEY_W-1:0] key = 48'h0000_0000_0123;
        int lat, nreads; logic hit; logic [PORT_W-1:0] port; logic [PROBE_W-1:0] probes;
        bit stable, clean;
        clear_mem();
        mem[12'h123] = ent(1'b1, 48'hAAAA_0000_0123, 4'h1);
        mem[12'h124] = ent(1'b1, 48'h0000_0000_0124, 4'h3);
        mem[12'h125] = ent(1'b1, key, 4'h2);
        run_lookup(key, 0, lat, hit, port, probes, nreads, stable, clean);
        checks++; if (lat !== 7) $display("FAIL chain_latency: got %0d expected 7", lat); else passes++;
        checks++; if (nreads !== 3 || addr_q[0] !== 12'h123 || addr_q[1] !== 12'h124 || addr_q[2] !== 12'h125)
            $display("FAIL chain_addr: got %0d reads %0h %0h %0h expected 123 124 125",
                     nreads, addr_q[0], addr_q[1], addr_q[2]);
        else passes++;
        checks++; if ({hit, port, probes} !== {1'b1, 4'h2, 3'd3})
            $display("FAIL chain_resp: got hit=%0b port=%0h probes=%0d expected 1/2/3", hit, port, probes);
        else passes++;
    endtask

    task automatic test_empty_miss();
        logic [KEY_W-1:0] key = 48'h0000_0000_0123;
        int lat, nreads; logic hit; logic [PORT_W-1:0] port; logic [PROBE_W-1:0] probes;
        bit stable, clean;
        clear_mem();
        // Stored key matches but the valid bit is clear: must be a miss.
        mem[12'h123] = ent(1'b0, key, 4'h9);
        mem[12'h124] = ent(1'b1, key, 4'hA);
        run_lookup(key, 0, lat, hit, port, probes, nreads, stable, clean);
        checks++; if ({hit, port, probes} !== {1'b0, 4'h0, 3'd1})
            $display("FAIL empty_resp: got hit=%0b port=%0h probes=%0d expected 0/0/1", hit, port, probes);
        else passes++;
        checks++; if (lat !== 3 || nreads !== 1)
            $display("FAIL empty_timing: got lat=%0d reads=%0d expected 3/1", lat, nreads);
        else passes++;
    endtask

    task automatic test_exhausted_miss();
        logic [KEY_W-1:0] key = 48'h0000_0000_0123;
        int lat, nreads; logic hit; logic [PORT_W-1:0] port; logic [PROBE_W-1:0] probes;
        bit stable, clean;
        clear_mem();
        for (int i = 0; i < 4; i++) mem[12'h123 + i] = ent(1'b1, key + 48'(i + 1) * 48'h1000, 4'(i + 1));
        mem[12'h127] = ent(1'b1, key, 4'h6);  // beyond the probe limit
        run_lookup(key, 3, lat, hit, port, probes, nreads, stable, clean);
        checks++; if ({hit, port, probes} !== {1'b0, 4'h0, 3'd4})
            $display("FAIL exhaust_resp: got hit=%0b port=%0h probes=%0d expected 0/0/4", hit, port, probes);
        else passes++;
        checks++; if (lat !== 9) $display("FAIL exhaust_latency: got %0d expected 9", lat); else passes++;
        checks++; if (nreads !== 4) $display("FAIL exhaust_reads: got %0d expected 4", nreads); else passes++;
        checks++; if (stable !== 1'b1) $display("FAIL exhaust_stable: got %0b expected 1", stable); else passes++;
    endtask

    task automatic test_wrap();
        logic [KEY_W-1:0] key = 48'h0000_0000_0FFF;
        int lat, nreads; logic hit; logic [PORT_W-1:0] port; logic [PROBE_W-1:0] probes;
        bit stable, clean;
        clear_mem();
        mem[12'hFFF] = ent(1'b1, 48'h0000_0001_0FFF, 4'h1);
        mem[12'h000] = ent(1'b1, key, 4'h7);
        run_lookup(key, 1, lat, hit, port, probes, nreads, stable, clean);
        checks++; if (nreads !== 2 || addr_q[0] !== 12'hFFF || addr_q[1] !== 12'h000)
            $display("FAIL wrap_addr: got %0d reads %0h %0h expected fff 000", nreads, addr_q[0], addr_q[1]);
        else passes++;
        checks++; if ({hit, port, probes} !== {1'b1, 4'h7, 3'd2})
            $display("FAIL wrap_resp: got hit=%0b port=%0h probes=%0d expected 1/7/2", hit, port, probes);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [KEY_W-1:0] key1 = 48'h0011_2233_4455;
        logic [KEY_W-1:0] key2 = 48'h0000_0000_0777;
        int n = 0;
        bit ok = 1'b1;
        clear_mem();
        mem[12'h642] = ent(1'b1, key1, 4'h5);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_key = key1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (resp_valid !== 1'b1) $display("FAIL bp_resp_timeout: got %0b expected 1", resp_valid);
        else passes++;
        req_key = key2; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if ({resp_valid, resp_hit, resp_port, resp_probes, req_ready, rd_en} !== {1'b1, 1'b1, 4'h5, 3'd1, 1'b0, 1'b0})
                ok = 1'b0;
        end
        checks++; if (ok !== 1'b1)
            $display("FAIL bp_hold: got v=%0b hit=%0b port=%0h probes=%0d ready=%0b expected 1/1/5/1/0",
                     resp_valid, resp_hit, resp_port, resp_probes, req_ready);
        else passes++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        addr_q.delete();
        checks++; if ({req_ready, resp_valid, rd_en} !== 3'b100)
            $display("FAIL bp_after_handshake: got ready=%0b valid=%0b rd_en=%0b expected 1/0/0",
                     req_ready, resp_valid, rd_en);
        else passes++;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rd_en !== 1'b1 || rd_addr !== 12'h777)
            $display("FAIL bp_second_accept: got rd_en=%0b addr=%0h expected 1/777", rd_en, rd_addr);
        else passes++;
        n = 1;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if ({resp_valid, resp_hit, resp_port, resp_probes} !== {1'b1, 1'b0, 4'h0, 3'd1})
            $display("FAIL bp_second_resp: got v=%0b hit=%0b port=%0h probes=%0d expected 1/0/0/1",
                     resp_valid, resp_hit, resp_port, resp_probes);
        else passes++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [KEY_W-1:0] key = 48'h0000_0000_0123;
        int n = 0;
        bit seen = 1'b0;
        clear_mem();
        for (int i = 0; i < 4; i++) mem[12'h123 + i] = ent(1'b1, key + 48'(i + 1) * 48'h1000, 4'(i + 1));
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_key = key; req_valid = 1'b1;
        @(negedge clk);                 // RD
        req_valid = 1'b0;
        @(negedge clk);                 // CMP of first probe
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rd_en, rd_addr, resp_valid, resp_hit, resp_port, resp_probes} !== '0)
            $display("FAIL midreset_outputs: got %0h expected 0",
                     {req_ready, rd_en, rd_addr, resp_valid, resp_hit, resp_port, resp_probes});
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %0b expected 1", req_ready);
        else passes++;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid || rd_en) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL midreset_no_resp: got %0b expected 0", seen);
        else passes++;
    endtask

    task automatic test_random();
        logic [KEY_W-1:0] stored [$];
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] h;
        logic e_hit; logic [PORT_W-1:0] e_port; int e_probes;
        int lat, nreads; logic hit; logic [PORT_W-1:0] port; logic [PROBE_W-1:0] probes;
        bit stable, clean, addr_ok;
        for (int t = 0; t < 40; t++) begin
            clear_mem();
            stored.delete();
            h = (t % 5 == 0) ? 12'hFFE : IDX_W'($urandom_range(0, DEPTH - 1));
            for (int s = 0; s < 6; s++) begin
                if ($urandom_range(0, 3) != 0) begin
                    key = key_with_hash(h);
                    stored.push_back(key);
                    mem[(int'(h) + s) % DEPTH] = ent(1'b1, key, PORT_W'($urandom));
                end
            end
            if (stored.size() > 0 && $urandom_range(0, 1) == 1)
                key = stored[$urandom_range(0, stored.size() - 1)];
            else
                key = key_with_hash(h);
            ref_lookup(key, e_hit, e_port, e_probes);
            run_lookup(key, $urandom_range(0, 3), lat, hit, port, probes, nreads, stable, clean);
            checks++; if ({hit, port} !== {e_hit, e_port})
                $display("FAIL rand_hitport[%0d]: got %0b/%0h expected %0b/%0h", t, hit, port, e_hit, e_port);
            else passes++;
            checks++; if (probes !== PROBE_W'(e_probes) || lat !== 1 + 2 * e_probes)
                $display("FAIL rand_probes[%0d]: got probes=%0d lat=%0d expected %0d/%0d",
                         t, probes, lat, e_probes, 1 + 2 * e_probes);
            else passes++;
            addr_ok = (nreads == e_probes);
            for (int i = 0; i < e_probes && i < nreads; i++)
                if (addr_q[i] !== IDX_W'((int'(h) + i) % DEPTH)) addr_ok = 1'b0;
            checks++; if (addr_ok !== 1'b1)
                $display("FAIL rand_addr[%0d]: got %0d reads from %0h expected %0d from %0h",
                         t, nreads, addr_q[0], e_probes, h);
            else passes++;
            checks++; if ({stable, clean} !== 2'b11)
                $display("FAIL rand_stable_clean[%0d]: got %0b%0b expected 11", t, stable, clean);
            else passes++;
        end
    endtask

    initial begin
        rd_data = '0;
        test_reset();
        test_home_hit();
        test_probe_chain();
        test_empty_miss();
        test_exhausted_miss();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
